// File: rtl/hw_monitor_pkg.sv
// hw_monitor_pkg
// Shared definitions for the hardware-monitor slice: the sensor collector's
// FSM state type, the per-channel status-word field positions (also used by
// the downstream APB register block), sensor type codes and two small helpers
// that build updated status words.
package hw_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_NEXT
  } collector_state_t;

  // Status word layout: {valid, timeout, count[5:0], data[23:0]}
  localparam int C_INFO_VALID_BIT = 31;
  localparam int C_INFO_TMO_BIT   = 30;
  localparam int C_INFO_CNT_MSB   = 29;
  localparam int C_INFO_CNT_LSB   = 24;
  localparam int C_INFO_DATA_MSB  = 23;
  localparam int C_INFO_DATA_LSB  = 0;

  localparam logic C_SENSOR_VOLT = 1'b0;
  localparam logic C_SENSOR_TEMP = 1'b1;

  // A good sample: mark valid, clear timeout, bump the wrapping count.
  function automatic logic [31:0] info_store(input logic [31:0] old_word,
                                             input logic [23:0] sample);
    logic [31:0] w;
    w = old_word;
    w[C_INFO_VALID_BIT] = 1'b1;
    w[C_INFO_TMO_BIT]   = 1'b0;
    w[C_INFO_CNT_MSB:C_INFO_CNT_LSB] = old_word[C_INFO_CNT_MSB:C_INFO_CNT_LSB] + 6'd1;
    w[C_INFO_DATA_MSB:C_INFO_DATA_LSB] = sample;
    return w;
  endfunction

  // A timed-out attempt only raises the timeout flag; history is kept.
  function automatic logic [31:0] info_timeout(input logic [31:0] old_word);
    logic [31:0] w;
    w = old_word;
    w[C_INFO_TMO_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/hw_sensor_timer.sv
// hw_sensor_timer
// Generic up-counter 0..P_COUNT-1 with a terminal-count pulse.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : synchronous return to 0 (has priority over enable)
//   enable      : count this cycle
//   tc          : high while enabled and at P_COUNT-1 (counter wraps on it)
module hw_sensor_timer #(
  parameter int P_COUNT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (P_COUNT > 1) ? $clog2(P_COUNT) : 1;
  localparam logic [W-1:0] C_LAST = W'(P_COUNT - 1);

  logic [W-1:0] count;

  assign tc = enable && (count == C_LAST);

  // Counter register; wraps to zero on the terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == C_LAST) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/hw_sensor_collector.sv
// hw_sensor_collector
// Periodically scans all voltage then all temperature sensor channels using a
// command/response handshake and keeps one status word per channel.
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   enable                         : allows new scans to start
//   cmd_valid/ready/sensor/channel : request to the sensor
//   rsp_valid/sensor/channel/data  : response strobe from the sensor
//   voltage_info, temperature_info : per-channel status words
//   scan_done                      : one-cycle pulse at scan end
//   overrun                        : sticky, a period tick was lost
module hw_sensor_collector
  import hw_monitor_pkg::*;
#(
  parameter int P_NO_CH_VOLT  = 9,
  parameter int P_NO_CH_TEMP  = 5,
  parameter int P_SCAN_PERIOD = 100000,
  parameter int P_TIMEOUT     = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic                          cmd_sensor,
  output logic [3:0]                    cmd_channel,
  input  logic                          rsp_valid,
  input  logic                          rsp_sensor,
  input  logic [3:0]                    rsp_channel,
  input  logic [23:0]                   rsp_data,
  output logic [P_NO_CH_VOLT-1:0][31:0] voltage_info,
  output logic [P_NO_CH_TEMP-1:0][31:0] temperature_info,
  output logic                          scan_done,
  output logic                          overrun
);

  collector_state_t state, state_next;
  logic       cur_sensor;
  logic [3:0] cur_channel;
  logic       tick_pending;
  logic       period_tick;
  logic       wait_tc;
  logic       rsp_match;
  logic       last_channel;
  logic       start_scan;
  logic       in_wait;

  assign in_wait      = (state == S_WAIT);
  assign rsp_match    = rsp_valid && (rsp_sensor == cur_sensor) && (rsp_channel == cur_channel);
  assign last_channel = (cur_sensor == C_SENSOR_TEMP) && (cur_channel == 4'(P_NO_CH_TEMP - 1));
  assign start_scan   = (state == S_IDLE) && enable && tick_pending;
  assign cmd_sensor   = cur_sensor;
  assign cmd_channel  = cur_channel;

  hw_sensor_timer #(.P_COUNT(P_SCAN_PERIOD)) u_period_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (1'b0),
    .enable (1'b1),
    .tc     (period_tick)
  );

  // Held at zero outside WAIT so every wait starts counting from 0.
  hw_sensor_timer #(.P_COUNT(P_TIMEOUT)) u_timeout_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .tc     (wait_tc)
  );

  // Scan sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and request strobe. A matching response beats a simultaneous timeout.
  always_comb begin
    state_next = state;
    cmd_valid  = 1'b0;
    case (state)
      S_IDLE:  if (start_scan) state_next = S_ISSUE;
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_match) state_next = S_STORE;
        else if (wait_tc) state_next = S_NEXT;
      end
      S_STORE: state_next = S_NEXT;
      S_NEXT:  state_next = last_channel ? S_IDLE : S_ISSUE;
      default: state_next = S_IDLE;
    endcase
  end

  // Channel index: voltage 0..N-1, then temperature 0..M-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_sensor  <= C_SENSOR_VOLT;
      cur_channel <= 4'd0;
    end else if (start_scan) begin
      cur_sensor  <= C_SENSOR_VOLT;
      cur_channel <= 4'd0;
    end else if ((state == S_NEXT) && !last_channel) begin
      if ((cur_sensor == C_SENSOR_VOLT) && (cur_channel == 4'(P_NO_CH_VOLT - 1))) begin
        cur_sensor  <= C_SENSOR_TEMP;
        cur_channel <= 4'd0;
      end else begin
        cur_channel <= cur_channel + 4'd1;
      end
    end
  end

  // Status words are written on leaving WAIT, so the update is visible in STORE
  // (or in NEXT after a timeout). Responses outside WAIT never reach here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      voltage_info     <= '0;
      temperature_info <= '0;
    end else if (in_wait) begin
      for (int i = 0; i < P_NO_CH_VOLT; i++) begin
        if ((cur_sensor == C_SENSOR_VOLT) && (cur_channel == 4'(i))) begin
          if (rsp_match) voltage_info[i] <= info_store(voltage_info[i], rsp_data);
          else if (wait_tc) voltage_info[i] <= info_timeout(voltage_info[i]);
        end
      end
      for (int i = 0; i < P_NO_CH_TEMP; i++) begin
        if ((cur_sensor == C_SENSOR_TEMP) && (cur_channel == 4'(i))) begin
          if (rsp_match) temperature_info[i] <= info_store(temperature_info[i], rsp_data);
          else if (wait_tc) temperature_info[i] <= info_timeout(temperature_info[i]);
        end
      end
    end
  end

  // Period bookkeeping: at most one tick is remembered; a second one while a
  // scan is still busy is lost and flagged. A fresh tick outranks the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      scan_done <= (state == S_NEXT) && last_channel;
      if (period_tick) begin
        tick_pending <= 1'b1;
        if ((state != S_IDLE) && tick_pending) overrun <= 1'b1;
      end else if (start_scan) begin
        tick_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hw_sensor_collector.sv
// tb_hw_sensor_collector
// Self-checking bench: a sensor model answers requests with random latency,
// stalls, stray responses and withheld answers; a scoreboard of per-channel
// fields and a period/tick timing model predict all observable results.
module tb_hw_sensor_collector;

  localparam int NV    = 9;
  localparam int NT    = 5;
  localparam int PER   = 100;
  localparam int TMO   = 16;
  localparam int LIMIT = 4 * PER;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic cmd_ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic rsp_sensor = 1'b0;
  logic [3:0] rsp_channel = 4'd0;
  logic [23:0] rsp_data = 24'd0;
  logic cmd_valid, cmd_sensor, scan_done, overrun;
  logic [3:0] cmd_channel;
  logic [NV-1:0][31:0] voltage_info;
  logic [NT-1:0][31:0] temperature_info;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int expStart = -1;
  bit expOverrun = 1'b0;

  bit mValid[2][16];
  bit mTmo[2][16];
  int mCnt[2][16];
  logic [23:0] mData[2][16];

  hw_sensor_collector #(
    .P_NO_CH_VOLT(NV), .P_NO_CH_TEMP(NT), .P_SCAN_PERIOD(PER), .P_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sensor(cmd_sensor),
    .cmd_channel(cmd_channel), .rsp_valid(rsp_valid), .rsp_sensor(rsp_sensor),
    .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .voltage_info(voltage_info), .temperature_info(temperature_info),
    .scan_done(scan_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Number of clock edges since reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelWord(input int s, input int ch);
    return {mValid[s][ch], mTmo[s][ch], 6'(mCnt[s][ch] % 64), mData[s][ch]};
  endfunction

  function automatic logic [31:0] dutWord(input int s, input int ch);
    return (s != 0) ? temperature_info[ch] : voltage_info[ch];
  endfunction

  task automatic clearModel();
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 16; c++) begin
        mValid[s][c] = 1'b0; mTmo[s][c] = 1'b0; mCnt[s][c] = 0; mData[s][c] = 24'd0;
      end
  endtask

  task automatic driveRsp(input bit v, input bit s, input int ch, input logic [23:0] d);
    rsp_valid = v; rsp_sensor = s; rsp_channel = 4'(ch); rsp_data = d;
  endtask

  // Serve one request: idx is the position in the scan order.
  task automatic applyStimulus(input int idx, input int expGap, input int stall, input int lat,
                               input bit withhold, input bit junk, input int junkCh,
                               input logic [23:0] data, output int startCyc, output int gapNext);
    int waits;
    int s;
    int ch;
    s = (idx >= NV) ? 1 : 0;
    ch = (idx >= NV) ? idx - NV : idx;
    startCyc = -1;
    gapNext = 0;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
      if (idx == 0 && waits == 1) checkOutput("donePulse", 32'(scan_done), 32'd0);
    end while (!cmd_valid && waits < LIMIT);
    checkOutput("reqSeen", 32'(cmd_valid), 32'd1);
    if (!cmd_valid) return;
    startCyc = cyc;
    if (expGap >= 0) checkOutput($sformatf("gap%0d", idx), 32'(waits), 32'(expGap));
    checkOutput("sensor", 32'(cmd_sensor), 32'(s));
    checkOutput("channel", 32'(cmd_channel), 32'(ch));
    for (int i = 0; i < stall; i++) begin
      // A matching answer during ISSUE must be dropped.
      if (i == 0) driveRsp(1'b1, s[0], ch, 24'hBADBAD);
      else rsp_valid = 1'b0;
      @(negedge clk);
      checkOutput("stallValid", 32'(cmd_valid), 32'd1);
      checkOutput("stallCmd", 32'({cmd_sensor, cmd_channel}), 32'({s[0], 4'(ch)}));
    end
    rsp_valid = 1'b0;
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checkOutput("validDrop", 32'(cmd_valid), 32'd0);
    if (withhold) begin
      for (int k = 0; k < TMO; k++) begin
        if (junk && k == 0) driveRsp(1'b1, ~s[0], junkCh, 24'($urandom));
        else rsp_valid = 1'b0;
        @(negedge clk);
      end
      rsp_valid = 1'b0;
      mTmo[s][ch] = 1'b1;
      gapNext = 1;
    end else begin
      for (int k = 0; k <= lat; k++) begin
        if (k == lat) driveRsp(1'b1, s[0], ch, data);
        else if (junk && k == 0) driveRsp(1'b1, ~s[0], junkCh, 24'($urandom));
        else rsp_valid = 1'b0;
        @(negedge clk);
      end
      rsp_valid = 1'b0;
      mValid[s][ch] = 1'b1;
      mTmo[s][ch] = 1'b0;
      mCnt[s][ch]++;
      mData[s][ch] = data;
      gapNext = 2;
    end
    checkOutput($sformatf("word%0d", idx), dutWord(s, ch), modelWord(s, ch));
  endtask

  // mode 0 random, 1 plain directed, 2 timeout/tie, 3 all withheld, 4 enable drop
  task automatic runScan(input int mode);
    int gap, gapOut, st, lat, jkCh, s0, sc, waits, c, n, r;
    bit wh, jk;
    logic [23:0] d;
    gap = -1;
    s0 = 0;
    for (int idx = 0; idx < NV + NT; idx++) begin
      r = int'($urandom_range(0, 7));
      st = int'($urandom_range(0, 2));
      lat = (r == 7) ? TMO - 1 : r % 4;
      wh = ($urandom_range(0, 11) == 0);
      jk = ($urandom_range(0, 3) == 0);
      jkCh = int'($urandom_range(0, 15));
      d = 24'($urandom);
      if (mode == 1) begin
        st = (idx == 0) ? 10 : 0; lat = 3; wh = 1'b0; jk = (idx == 5); jkCh = 3;
        d = 24'(32'h100 + ((idx >= NV) ? idx - NV : idx));
      end else if (mode == 2) begin
        st = 0; lat = (idx == 3) ? TMO - 1 : 2; wh = (idx == NV + 1); jk = 1'b0;
      end else if (mode == 3) begin
        wh = 1'b1;
      end
      if (mode == 4 && idx == 2) enable = 1'b0;
      if (jk && lat == 0) lat = 1;
      applyStimulus(idx, gap, st, lat, wh, jk, jkCh, d, sc, gapOut);
      gap = gapOut;
      if (idx == 0) begin
        s0 = sc;
        if (expStart >= 0) checkOutput("scanStart", 32'(sc), 32'(expStart));
      end
    end
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!scan_done && waits < LIMIT);
    checkOutput("doneGap", 32'(waits), 32'(gap));
    c = cyc;
    n = c / PER - (s0 - 1) / PER;
    if (n >= 2) expOverrun = 1'b1;
    checkOutput("overrun", 32'(overrun), 32'(expOverrun));
    expStart = (n >= 1) ? c + 1 : (c / PER + 1) * PER + 1;
    for (int i = 0; i < NV; i++) checkOutput($sformatf("volt%0d", i), voltage_info[i], modelWord(0, i));
    for (int i = 0; i < NT; i++) checkOutput($sformatf("temp%0d", i), temperature_info[i], modelWord(1, i));
  endtask

  initial begin
    int waits;
    bit sawValid;
    clearModel();
    enable = 1'b1;
    #1;
    checkOutput("rstValid", 32'(cmd_valid), 32'd0);
    checkOutput("rstCmd", 32'({cmd_sensor, cmd_channel}), 32'd0);
    checkOutput("rstDone", 32'({scan_done, overrun}), 32'd0);
    checkOutput("rstInfo", 32'((voltage_info != '0) || (temperature_info != '0)), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expStart = PER + 1;

    runScan(1);
    checkOutput("v2Spec", voltage_info[2], 32'h81000102);
    checkOutput("t4Spec", temperature_info[4], 32'h81000104);
    runScan(2);
    checkOutput("t1Keep", temperature_info[1], 32'hC1000101);
    repeat (4) runScan(0);
    runScan(3);
    checkOutput("overrunSet", 32'(overrun), 32'd1);
    runScan(0);

    // Drop enable mid-scan: the scan completes, then nothing starts until enable returns.
    runScan(4);
    sawValid = 1'b0;
    repeat (2 * PER) begin
      @(negedge clk);
      sawValid |= cmd_valid;
    end
    checkOutput("enableHold", 32'(sawValid), 32'd0);
    enable = 1'b1;
    expStart = cyc + 1;
    runScan(0);

    // Reset in the middle of a wait, then a late response after release.
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!cmd_valid && waits < LIMIT);
    checkOutput("rstReq", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(cmd_valid), 32'd0);
    checkOutput("midRstFlags", 32'({scan_done, overrun}), 32'd0);
    checkOutput("midRstInfo", 32'((voltage_info != '0) || (temperature_info != '0)), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    driveRsp(1'b1, 1'b0, 0, 24'h123456);
    @(negedge clk);
    rsp_valid = 1'b0;
    @(negedge clk);
    checkOutput("lateRspInfo", 32'((voltage_info != '0) || (temperature_info != '0)), 32'd0);
    checkOutput("lateRspValid", 32'(cmd_valid), 32'd0);
    clearModel();
    expOverrun = 1'b0;
    expStart = PER + 1;
    runScan(0);
    runScan(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
